// File: rtl/glip_uart_tx_scheduler_if.sv
// Byte-channel bundle between the egress/credit/control sources, the tx scheduler
// and the UART transmitter.
interface glip_uart_tx_scheduler_if #(
   parameter int unsigned CTRL_WIDTH = 16
);
   logic [7:0]            data_in_data;
   logic                  data_in_valid;
   logic                  data_in_ready;
   logic                  can_send;
   logic [CTRL_WIDTH-1:0] ctrl_in_data;
   logic                  ctrl_in_valid;
   logic                  ctrl_in_ready;
   logic [7:0]            out_data;
   logic                  out_enable;
   logic                  out_done;
   logic                  transfer;
   logic                  error;

   modport slave (
      input  data_in_data, data_in_valid, can_send, ctrl_in_data, ctrl_in_valid, out_done,
      output data_in_ready, ctrl_in_ready, out_data, out_enable, transfer, error
   );

   modport master (
      output data_in_data, data_in_valid, can_send, ctrl_in_data, ctrl_in_valid, out_done,
      input  data_in_ready, ctrl_in_ready, out_data, out_enable, transfer, error
   );
endinterface

// File: rtl/glip_uart_tx_scheduler.sv
// Shares the UART transmit byte channel between escaped payload bytes and atomic
// 3-byte control messages, alternating fairly when both are pending.
module glip_uart_tx_scheduler #(
   parameter logic [7:0]  ESCAPE     = 8'hFE,
   parameter int unsigned CTRL_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   glip_uart_tx_scheduler_if.slave  bus
);

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      DATA_ESC,
      CTRL_ESC,
      CTRL_CMD,
      CTRL_ARG
   } state_e;

   state_e                 state_q, state_d;
   logic [BYTE_W-1:0]      out_data_q, out_data_d;
   logic                   out_en_q, out_en_d;
   logic                   xfer_q, xfer_d;
   logic                   err_q, err_d;
   logic                   last_ctrl_q, last_ctrl_d;
   logic [CTRL_WIDTH-1:0]  msg_q, msg_d;

   logic                   data_ok;
   logic                   grant_data;
   logic                   grant_ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_data_q  <= '0;
         out_en_q    <= 1'b0;
         xfer_q      <= 1'b0;
         err_q       <= 1'b0;
         last_ctrl_q <= 1'b0;
         msg_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_en_q    <= out_en_d;
         xfer_q      <= xfer_d;
         err_q       <= err_d;
         last_ctrl_q <= last_ctrl_d;
         msg_q       <= msg_d;
      end
   end

   // Arbitration in IDLE only; a served ctrl message yields the next slot to pending data.
   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_en_d    = out_en_q;
      xfer_d      = 1'b0;
      err_d       = err_q;
      last_ctrl_d = last_ctrl_q;
      msg_d       = msg_q;
      grant_data  = 1'b0;
      grant_ctrl  = 1'b0;
      data_ok     = bus.data_in_valid & bus.can_send;

      case (state_q)
         IDLE: begin
            if (bus.ctrl_in_valid && (!data_ok || !last_ctrl_q)) begin
               grant_ctrl = 1'b1;
               state_d    = CTRL_ESC;
               msg_d      = bus.ctrl_in_data;
               out_data_d = ESCAPE;
               out_en_d   = 1'b1;
               if (bus.ctrl_in_data[CTRL_WIDTH-1 -: BYTE_W] == ESCAPE) begin
                  err_d = 1'b1;
               end
            end else if (data_ok) begin
               grant_data  = 1'b1;
               state_d     = DATA;
               out_data_d  = bus.data_in_data;
               out_en_d    = 1'b1;
               last_ctrl_d = 1'b0;
            end
         end
         DATA: begin
            if (bus.out_done) begin
               // An escape-valued payload byte goes out twice; out_data already holds it.
               if (out_data_q == ESCAPE) begin
                  state_d = DATA_ESC;
               end else begin
                  state_d  = IDLE;
                  out_en_d = 1'b0;
                  xfer_d   = 1'b1;
               end
            end
         end
         DATA_ESC: begin
            if (bus.out_done) begin
               state_d  = IDLE;
               out_en_d = 1'b0;
               xfer_d   = 1'b1;
            end
         end
         CTRL_ESC: begin
            if (bus.out_done) begin
               state_d    = CTRL_CMD;
               out_data_d = msg_q[CTRL_WIDTH-1 -: BYTE_W];
            end
         end
         CTRL_CMD: begin
            if (bus.out_done) begin
               state_d    = CTRL_ARG;
               out_data_d = msg_q[BYTE_W-1:0];
            end
         end
         CTRL_ARG: begin
            if (bus.out_done) begin
               state_d     = IDLE;
               out_en_d    = 1'b0;
               last_ctrl_d = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            out_en_d = 1'b0;
         end
      endcase

      if (bus.out_done && !out_en_q) begin
         err_d = 1'b1;
      end
   end

   assign bus.data_in_ready = grant_data & ~rst;
   assign bus.ctrl_in_ready = grant_ctrl & ~rst;
   assign bus.out_data      = out_data_q;
   assign bus.out_enable    = out_en_q;
   assign bus.transfer      = xfer_q;
   assign bus.error         = err_q;

endmodule

// File: tb/tb_glip_uart_tx_scheduler.sv
// Directed bench for glip_uart_tx_scheduler: escaping, ctrl framing, fairness,
// credit gating, error flagging and mid-token reset.
module tb_glip_uart_tx_scheduler;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   xfer_cnt;

   glip_uart_tx_scheduler_if #(.CTRL_WIDTH(16)) u_if ();

   glip_uart_tx_scheduler #(
      .ESCAPE     (8'hFE),
      .CTRL_WIDTH (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (u_if.transfer === 1'b1) xfer_cnt <= xfer_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_n(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one payload byte at an IDLE negedge; expect accept and 1-cycle latency.
   task automatic accept_data(input logic [7:0] d, input string tag);
      u_if.data_in_data  = d;
      u_if.data_in_valid = 1'b1;
      u_if.can_send      = 1'b1;
      #1;
      chk_b({tag, "_ready"}, u_if.data_in_ready, 1'b1);
      @(negedge clk);
      u_if.data_in_valid = 1'b0;
      chk_b({tag, "_lat"}, u_if.out_enable, 1'b1);
   endtask

   // Transmitter model: check the byte, hold it, then a 1-cycle out_done.
   task automatic serve(input logic [7:0] exp, input string tag);
      chk_b({tag, "_en"}, u_if.out_enable, 1'b1);
      chk_8({tag, "_byte"}, u_if.out_data, exp);
      @(negedge clk);
      chk_b({tag, "_hold"}, u_if.out_enable, 1'b1);
      @(negedge clk);
      u_if.out_done = 1'b1;
      @(negedge clk);
      u_if.out_done = 1'b0;
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      xfer_cnt = 0;
      rst                = 1'b1;
      u_if.data_in_data  = 8'h00;
      u_if.data_in_valid = 1'b1;
      u_if.can_send      = 1'b1;
      u_if.ctrl_in_data  = 16'h8105;
      u_if.ctrl_in_valid = 1'b1;
      u_if.out_done      = 1'b0;

      // Reset values, with requests pending during reset
      repeat (3) @(negedge clk);
      #1;
      chk_b("rst_data_ready", u_if.data_in_ready, 1'b0);
      chk_b("rst_ctrl_ready", u_if.ctrl_in_ready, 1'b0);
      chk_b("rst_out_enable", u_if.out_enable, 1'b0);
      chk_8("rst_out_data", u_if.out_data, 8'h00);
      chk_b("rst_transfer", u_if.transfer, 1'b0);
      chk_b("rst_error", u_if.error, 1'b0);
      u_if.data_in_valid = 1'b0;
      u_if.ctrl_in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Payload 41, FE, 42 -> wire 41 FE FE 42
      accept_data(8'h41, "d41");
      serve(8'h41, "d41");
      chk_b("d41_xfer", u_if.transfer, 1'b1);
      chk_b("d41_gap", u_if.out_enable, 1'b0);
      accept_data(8'hFE, "dfe");
      serve(8'hFE, "dfe_a");
      chk_b("dfe_mid_xfer", u_if.transfer, 1'b0);
      chk_b("dfe_mid_en", u_if.out_enable, 1'b1);
      serve(8'hFE, "dfe_b");
      chk_b("dfe_xfer", u_if.transfer, 1'b1);
      accept_data(8'h42, "d42");
      serve(8'h42, "d42");
      chk_b("d42_xfer", u_if.transfer, 1'b1);
      @(negedge clk);
      chk_b("d42_xfer_pulse", u_if.transfer, 1'b0);
      chk_n("data_xfer_cnt", xfer_cnt, 3);

      // Control message 8105 -> wire FE 81 05, no transfer
      u_if.ctrl_in_data  = 16'h8105;
      u_if.ctrl_in_valid = 1'b1;
      #1;
      chk_b("c8105_ready", u_if.ctrl_in_ready, 1'b1);
      chk_b("c8105_dready", u_if.data_in_ready, 1'b0);
      @(negedge clk);
      u_if.ctrl_in_valid = 1'b0;
      serve(8'hFE, "c8105_esc");
      chk_b("c8105_x1", u_if.transfer, 1'b0);
      serve(8'h81, "c8105_cmd");
      chk_b("c8105_x2", u_if.transfer, 1'b0);
      serve(8'h05, "c8105_arg");
      chk_b("c8105_x3", u_if.transfer, 1'b0);
      chk_b("c8105_end_en", u_if.out_enable, 1'b0);
      chk_b("c8105_err", u_if.error, 1'b0);
      @(negedge clk);
      chk_n("ctrl_xfer_cnt", xfer_cnt, 3);

      // Credit gating: no credit -> no accept
      u_if.data_in_data  = 8'h55;
      u_if.data_in_valid = 1'b1;
      u_if.can_send      = 1'b0;
      #1;
      chk_b("nocred_ready", u_if.data_in_ready, 1'b0);
      repeat (3) @(negedge clk);
      chk_b("nocred_en", u_if.out_enable, 1'b0);
      chk_b("nocred_ready2", u_if.data_in_ready, 1'b0);
      u_if.can_send = 1'b1;
      #1;
      chk_b("cred_ready", u_if.data_in_ready, 1'b1);
      @(negedge clk);
      u_if.data_in_valid = 1'b0;
      serve(8'h55, "cred");
      chk_b("cred_xfer", u_if.transfer, 1'b1);
      @(negedge clk);
      chk_n("cred_xfer_cnt", xfer_cnt, 4);

      // Fairness: both sources continuously valid
      u_if.ctrl_in_data  = 16'h1234;
      u_if.ctrl_in_valid = 1'b1;
      u_if.data_in_data  = 8'h10;
      u_if.data_in_valid = 1'b1;
      #1;
      chk_b("fair1_ctrl", u_if.ctrl_in_ready, 1'b1);
      chk_b("fair1_data", u_if.data_in_ready, 1'b0);
      @(negedge clk);
      u_if.ctrl_in_data = 16'h5678;
      serve(8'hFE, "fair1_esc");
      serve(8'h12, "fair1_cmd");
      serve(8'h34, "fair1_arg");
      #1;
      chk_b("fair2_data", u_if.data_in_ready, 1'b1);
      chk_b("fair2_ctrl", u_if.ctrl_in_ready, 1'b0);
      @(negedge clk);
      u_if.data_in_data = 8'h11;
      serve(8'h10, "fair2_byte");
      #1;
      chk_b("fair3_ctrl", u_if.ctrl_in_ready, 1'b1);
      @(negedge clk);
      u_if.ctrl_in_data = 16'h9ABC;
      serve(8'hFE, "fair3_esc");
      serve(8'h56, "fair3_cmd");
      serve(8'h78, "fair3_arg");
      #1;
      chk_b("fair4_data", u_if.data_in_ready, 1'b1);
      chk_b("fair4_ctrl", u_if.ctrl_in_ready, 1'b0);
      @(negedge clk);
      u_if.data_in_valid = 1'b0;
      u_if.ctrl_in_valid = 1'b0;
      serve(8'h11, "fair4_byte");
      @(negedge clk);
      chk_n("fair_xfer_cnt", xfer_cnt, 6);

      // Escape-valued command flags error but is still sent
      u_if.ctrl_in_data  = 16'hFE00;
      u_if.ctrl_in_valid = 1'b1;
      #1;
      chk_b("cfe_ready", u_if.ctrl_in_ready, 1'b1);
      @(negedge clk);
      u_if.ctrl_in_valid = 1'b0;
      chk_b("cfe_err", u_if.error, 1'b1);
      serve(8'hFE, "cfe_esc");
      serve(8'hFE, "cfe_cmd");
      serve(8'h00, "cfe_arg");
      chk_b("cfe_err_sticky", u_if.error, 1'b1);

      // Reset clears error; out_done while idle sets it
      rst = 1'b1;
      @(negedge clk);
      chk_b("rst2_err", u_if.error, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      u_if.out_done = 1'b1;
      @(negedge clk);
      u_if.out_done = 1'b0;
      chk_b("idle_done_err", u_if.error, 1'b1);
      chk_b("idle_done_en", u_if.out_enable, 1'b0);
      chk_b("idle_done_xfer", u_if.transfer, 1'b0);
      @(negedge clk);
      chk_b("idle_done_sticky", u_if.error, 1'b1);

      // Reset in the middle of a control message
      u_if.ctrl_in_data  = 16'h8105;
      u_if.ctrl_in_valid = 1'b1;
      #1;
      chk_b("mid_ready", u_if.ctrl_in_ready, 1'b1);
      @(negedge clk);
      u_if.ctrl_in_valid = 1'b0;
      serve(8'hFE, "mid_esc");
      chk_b("mid_cmd_en", u_if.out_enable, 1'b1);
      chk_8("mid_cmd_byte", u_if.out_data, 8'h81);
      rst = 1'b1;
      @(negedge clk);
      chk_b("mid_rst_en", u_if.out_enable, 1'b0);
      chk_8("mid_rst_data", u_if.out_data, 8'h00);
      chk_b("mid_rst_err", u_if.error, 1'b0);
      chk_b("mid_rst_xfer", u_if.transfer, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_b("mid_no_resume", u_if.out_enable, 1'b0);
      end
      accept_data(8'h33, "post");
      serve(8'h33, "post");
      chk_b("post_xfer", u_if.transfer, 1'b1);
      @(negedge clk);
      chk_n("final_xfer_cnt", xfer_cnt, 7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/glip_uart_tx_scheduler.md
Name: glip_uart_tx_scheduler

Overview:
- Shares the single UART transmit byte channel between two requesters: the egress payload stream (credit-gated) and control messages (credit grants, reset acknowledges).
- Applies byte escaping to payload, serialises each 3-byte control message atomically, and enforces fairness between the two sources.
- Sits between the egress FIFO / credit logic and the UART transmitter (enable/done byte interface).

Parameters:
- ESCAPE, 8'hFE, escape byte value on the wire.
- CTRL_WIDTH, 16, control message payload width. Fixed at 16: two body bytes.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- data_in_data  input  8  payload byte
- data_in_valid  input  1  payload byte available
- data_in_ready  output  1  payload byte accepted this cycle (valid & ready)
- can_send  input  1  debt/credit permits a payload byte
- ctrl_in_data  input  16  control message body; [15:8] command, [7:0] argument
- ctrl_in_valid  input  1  control message pending
- ctrl_in_ready  output  1  control message accepted this cycle
- out_data  output  8  byte to UART transmitter
- out_enable  output  1  byte valid; held until out_done
- out_done  input  1  transmitter finished the current byte (1-cycle pulse)
- transfer  output  1  1-cycle pulse when a payload byte is fully on the wire
- error  output  1  sticky protocol error

Behaviour:
- Reset values: data_in_ready=0, ctrl_in_ready=0, out_enable=0, out_data=0, transfer=0, error=0, state=IDLE, last_was_ctrl=0.
- States: IDLE, DATA, DATA_ESC, CTRL_ESC, CTRL_CMD, CTRL_ARG.
- Arbitration happens only in IDLE.
  - data_ok = data_in_valid & can_send.
  - Grant ctrl if ctrl_in_valid and (!data_ok or !last_was_ctrl).
  - Else grant data if data_ok.
  - Result: ctrl has priority, but after a ctrl message a pending data byte is always served next. No source is starved.
- Data grant:
  - data_in_ready=1 combinationally in IDLE; the byte is latched.
  - Next state is DATA. out_enable=1 and out_data=latched byte from the following cycle.
  - On out_done in DATA: if the byte == ESCAPE, go to DATA_ESC (send ESCAPE again); else pulse transfer and return to IDLE.
  - On out_done in DATA_ESC: pulse transfer, go to IDLE.
  - Set last_was_ctrl=0.
- Ctrl grant:
  - ctrl_in_ready=1 in IDLE; the 16-bit body is latched.
  - Sequence: CTRL_ESC sends ESCAPE, CTRL_CMD sends [15:8], CTRL_ARG sends [7:0]. Each step advances on out_done.
  - After CTRL_ARG completes, go to IDLE and set last_was_ctrl=1.
  - If [15:8]==ESCAPE at acceptance, set error; the message is still sent unchanged.
- Byte timing:
  - Between bytes of one token, out_enable stays high. out_data changes in the cycle after out_done.
  - Between tokens, out_enable is low for exactly one cycle (the IDLE cycle).
  - Minimum token latency from accept to first out_enable: 1 cycle.
- can_send is sampled only at arbitration. Deassertion mid-token does not abort the token.
- A ctrl message is never interleaved with data, and a data escape pair is never split.
- out_done while out_enable=0 sets error and is otherwise ignored.
- error is sticky until rst.
- Simultaneous out_done and new requests: requests are only evaluated after the FSM returns to IDLE.
- rst mid-token: immediate return to IDLE and outputs to reset values. The latched byte/message is discarded, with no transfer pulse and no partial completion.

Test Plan:
- Data only, can_send=1, bytes 0x41,0xFE,0x42, out_done 3 cycles after each enable -> wire 41,FE,FE,42; transfer pulses 3 times, only after the last byte of each token.
- can_send=0 with data_in_valid=1 -> data_in_ready stays 0 and out_enable stays 0; raise can_send -> byte sent, transfer=1 once.
- ctrl_in_data=16'h8105 alone -> wire FE,81,05; ctrl_in_ready pulses once at accept; transfer never pulses.
- data and ctrl both continuously valid -> order ctrl(FE,xx,yy), data byte, ctrl, data, ...; no two ctrl messages back-to-back while data is pending.
- ctrl_in_data=16'hFE00 -> error=1 and stays 1; out_done pulse while out_enable=0 -> error=1.
- rst asserted during CTRL_CMD -> next cycle out_enable=0, state IDLE, no ctrl bytes resumed; error cleared.
